// File: rtl/stage_preif_pkg.sv
// Shared constants and types for the pre-IF stage.
package stage_preif_pkg;

   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h1c000000;

   // Winning redirect source, also useful for debug visibility.
   typedef enum logic [1:0] {
      REDIR_NONE = 2'd0,
      REDIR_EX   = 2'd1,
      REDIR_ERTN = 2'd2,
      REDIR_BR   = 2'd3
   } redir_src_e;

endpackage

// File: rtl/stage_preif_npc_mux.sv
// Next-PC selection: priority redirect mux (ex > ertn > br) plus sequential PC adder.
module preif_npc_mux
   import stage_preif_pkg::*;
(
   input  logic [INST_W-1:0] pc_i,
   input  logic              ex_flush_i,
   input  logic [INST_W-1:0] ex_entry_i,
   input  logic              ertn_flush_i,
   input  logic [INST_W-1:0] era_i,
   input  logic              br_taken_i,
   input  logic [INST_W-1:0] br_target_i,
   output logic [1:0]        src_o,
   output logic [INST_W-1:0] nextpc_o
);

   redir_src_e src;
   logic [INST_W-1:0] seqPc;

   assign seqPc = pc_i + 32'd4;

   always_comb begin
      src      = REDIR_NONE;
      nextpc_o = seqPc;
      if (ex_flush_i) begin
         src      = REDIR_EX;
         nextpc_o = ex_entry_i;
      end else if (ertn_flush_i) begin
         src      = REDIR_ERTN;
         nextpc_o = era_i;
      end else if (br_taken_i) begin
         src      = REDIR_BR;
         nextpc_o = br_target_i;
      end
   end

   assign src_o = src;

endmodule

// File: rtl/stage_preif.sv
// Pre-IF stage: owns the fetch PC and issues the inst SRAM read one cycle ahead of stage_if.
module stage_preif
   import stage_preif_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        allowout,
   output logic        validout,
   output logic        cancel_out,
   output logic [31:0] output_pc,
   output logic        output_adef,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        ex_flush,
   input  logic [31:0] ex_entry,
   input  logic        ertn_flush,
   input  logic [31:0] era,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata
);

   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] nextPc;
   logic [1:0]  redirSrc;
   logic        redirect;
   logic        fire;
   logic        load;

   preif_npc_mux uNpcMux (
      .pc_i         (pc_q),
      .ex_flush_i   (ex_flush),
      .ex_entry_i   (ex_entry),
      .ertn_flush_i (ertn_flush),
      .era_i        (era),
      .br_taken_i   (br_taken),
      .br_target_i  (br_target),
      .src_o        (redirSrc),
      .nextpc_o     (nextPc)
   );

   // An empty stage always refills; a redirect loads even while stage_if stalls.
   assign redirect = (redirSrc != REDIR_NONE);
   assign fire     = allowout | ~valid_q;
   assign load     = redirect | fire;

   always_comb begin
      pc_d    = pc_q;
      valid_d = valid_q;
      if (load) begin
         pc_d    = nextPc;
         valid_d = 1'b1;
      end
   end

   // Reset PC sits one word before RESET_PC so the first sequential step fetches RESET_PC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC - 32'd4;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   // While stalled the current PC is re-presented so rdata stays aligned with it.
   assign inst_sram_en    = ~rst;
   assign inst_sram_we    = 4'b0;
   assign inst_sram_wdata = 32'b0;
   assign inst_sram_addr  = load ? nextPc : pc_q;

   assign validout    = valid_q & ~redirect;
   assign cancel_out  = redirect;
   assign output_pc   = pc_q;
   assign output_adef = valid_q & (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_stage_preif.sv
// Directed self-checking bench for stage_preif: reset, stall, redirects, priority, misalignment, async reset.
module tb_stage_preif;

   logic        clk;
   logic        rst;
   logic        allowout;
   logic        validout;
   logic        cancel_out;
   logic [31:0] output_pc;
   logic        output_adef;
   logic        br_taken;
   logic [31:0] br_target;
   logic        ex_flush;
   logic [31:0] ex_entry;
   logic        ertn_flush;
   logic [31:0] era;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;

   int checkCount;
   int errorCount;

   stage_preif dut (
      .clk             (clk),
      .rst             (rst),
      .allowout        (allowout),
      .validout        (validout),
      .cancel_out      (cancel_out),
      .output_pc       (output_pc),
      .output_adef     (output_adef),
      .br_taken        (br_taken),
      .br_target       (br_target),
      .ex_flush        (ex_flush),
      .ex_entry        (ex_entry),
      .ertn_flush      (ertn_flush),
      .era             (era),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Drive redirect inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic allow, input logic ex, input logic ertn, input logic br,
                                input logic [31:0] brTgt);
      allowout   = allow;
      ex_flush   = ex;
      ertn_flush = ertn;
      br_taken   = br;
      br_target  = brTgt;
      #1;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst        = 1'b1;
      ex_entry   = 32'h1c008000;
      era        = 32'h1c000200;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      @(posedge clk);
      #1;
      checkOutput("rst_en", {31'b0, inst_sram_en}, 32'd0);
      checkOutput("rst_valid", {31'b0, validout}, 32'd0);
      checkOutput("sram_we", {28'b0, inst_sram_we}, 32'd0);
      checkOutput("sram_wdata", inst_sram_wdata, 32'd0);

      // Reset release with allowout held high
      rst = 1'b0;
      #1;
      checkOutput("c0_addr", inst_sram_addr, 32'h1c000000);
      checkOutput("c0_valid", {31'b0, validout}, 32'd0);
      checkOutput("c0_en", {31'b0, inst_sram_en}, 32'd1);
      stepCycle();
      checkOutput("c1_pc", output_pc, 32'h1c000000);
      checkOutput("c1_valid", {31'b0, validout}, 32'd1);
      stepCycle();
      checkOutput("c2_pc", output_pc, 32'h1c000004);
      checkOutput("c2_valid", {31'b0, validout}, 32'd1);

      // Stall three cycles on 0x1c000004
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("stall_pc", output_pc, 32'h1c000004);
         checkOutput("stall_addr", inst_sram_addr, 32'h1c000004);
         checkOutput("stall_valid", {31'b0, validout}, 32'd1);
         if (i < 2) stepCycle();
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("unstall_addr", inst_sram_addr, 32'h1c000008);
      stepCycle();
      checkOutput("c3_pc", output_pc, 32'h1c000008);
      checkOutput("c3_valid", {31'b0, validout}, 32'd1);

      // Branch while stalled
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h1c000100);
      checkOutput("br_cancel", {31'b0, cancel_out}, 32'd1);
      checkOutput("br_valid", {31'b0, validout}, 32'd0);
      checkOutput("br_addr", inst_sram_addr, 32'h1c000100);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("br_pc", output_pc, 32'h1c000100);
      checkOutput("br_post_valid", {31'b0, validout}, 32'd1);
      checkOutput("br_post_cancel", {31'b0, cancel_out}, 32'd0);
      checkOutput("br_stall_addr", inst_sram_addr, 32'h1c000100);

      // All three redirects together: exception wins
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h1c000100);
      checkOutput("prio_addr", inst_sram_addr, 32'h1c008000);
      checkOutput("prio_cancel", {31'b0, cancel_out}, 32'd1);
      stepCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("prio_pc", output_pc, 32'h1c008000);

      // ertn beats branch
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h1c000100);
      checkOutput("ertn_addr", inst_sram_addr, 32'h1c000200);
      stepCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("ertn_pc", output_pc, 32'h1c000200);
      checkOutput("ertn_adef", {31'b0, output_adef}, 32'd0);

      // Misaligned branch target is flagged and keeps flowing
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h1c000102);
      stepCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("mis_pc", output_pc, 32'h1c000102);
      checkOutput("mis_adef", {31'b0, output_adef}, 32'd1);
      checkOutput("mis_addr", inst_sram_addr, 32'h1c000106);
      stepCycle();
      checkOutput("mis_next_pc", output_pc, 32'h1c000106);
      checkOutput("mis_next_adef", {31'b0, output_adef}, 32'd1);

      // Sequential PC wraps from the top of the address space
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hfffffffc);
      stepCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("wrap_top_pc", output_pc, 32'hfffffffc);
      checkOutput("wrap_addr", inst_sram_addr, 32'h00000000);
      stepCycle();
      checkOutput("wrap_pc", output_pc, 32'h00000000);

      // Async reset mid-stream at pc = 0x1c000010
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h1c000010);
      stepCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("pre_rst_pc", output_pc, 32'h1c000010);
      checkOutput("pre_rst_valid", {31'b0, validout}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_valid", {31'b0, validout}, 32'd0);
      checkOutput("async_pc", output_pc, 32'h1bfffffc);
      checkOutput("async_en", {31'b0, inst_sram_en}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("rel_addr", inst_sram_addr, 32'h1c000000);
      checkOutput("rel_valid", {31'b0, validout}, 32'd0);
      stepCycle();
      checkOutput("rel_pc", output_pc, 32'h1c000000);
      checkOutput("rel_valid1", {31'b0, validout}, 32'd1);
      stepCycle();
      checkOutput("rel_pc2", output_pc, 32'h1c000004);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
